pcpi_m_dispatch: RTL and testbench

PCPI_M_DISPATCH -- requirements
Module: pcpi_m_dispatch

---
 rtl/pcpi_m_dispatch.sv | 163 ++++++++++++++++
 tb/tb_pcpi_m_dispatch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_m_dispatch.sv
// PCPI bridge that forwards RV32M instructions to an external M-extension coprocessor.
// Handles issue, result writeback, core-side aborts, and cycle timeouts that end in a drain.
module pcpi_m_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    output logic        cp_valid,
    output logic [31:0] cp_instruction,
    output logic [31:0] cp_rs1,
    output logic [31:0] cp_rs2,
    input  logic        cp_ready,
    input  logic        cp_busy,
    input  logic [31:0] cp_rd,
    output logic        timeout_err,
    output logic [15:0] op_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_cnt_hit;
    logic               w_m_decode;
    logic [31:0]        r_insn, r_rs1, r_rs2;
    logic [31:0]        w_insn_nxt, w_rs1_nxt, w_rs2_nxt;
    logic [31:0]        r_rd, w_rd_nxt;
    logic               r_cp_valid, r_wait, r_ready, r_wr, r_timeout;
    logic               w_cp_valid_nxt, w_wait_nxt, w_resp_nxt, w_timeout_nxt;
    logic [15:0]        r_op_count, w_op_count_nxt;

    assign w_m_decode = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_cnt_hit  = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_insn_nxt     = r_insn;
        w_rs1_nxt      = r_rs1;
        w_rs2_nxt      = r_rs2;
        w_rd_nxt       = 32'd0;
        w_timeout_nxt  = r_timeout;
        w_op_count_nxt = r_op_count;

        case (r_state)
            S_IDLE: begin
                if (pcpi_valid && w_m_decode) begin
                    w_state_nxt = S_ISSUE;
                    w_insn_nxt  = pcpi_insn;
                    w_rs1_nxt   = pcpi_rs1;
                    w_rs2_nxt   = pcpi_rs2;
                    w_cnt_nxt   = '0;
                end
            end
            S_ISSUE, S_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                // Abort beats a coincident cp_ready; the coprocessor is then already done.
                if (!pcpi_valid) begin
                    w_state_nxt = cp_ready ? S_IDLE : S_DRAIN;
                    w_cnt_nxt   = '0;
                end else if (cp_ready) begin
                    w_state_nxt    = S_RESP;
                    w_rd_nxt       = cp_rd;
                    w_op_count_nxt = r_op_count + 16'd1;
                end else if (w_cnt_hit) begin
                    w_state_nxt   = S_DRAIN;
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else if ((r_state == S_ISSUE) && cp_busy) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!pcpi_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_cnt_nxt = w_cnt_inc;
                if (cp_ready) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_hit) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_cp_valid_nxt = (w_state_nxt == S_ISSUE);
        w_wait_nxt     = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
        w_resp_nxt     = (w_state_nxt == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_insn     <= 32'd0;
            r_rs1      <= 32'd0;
            r_rs2      <= 32'd0;
            r_rd       <= 32'd0;
            r_cp_valid <= 1'b0;
            r_wait     <= 1'b0;
            r_ready    <= 1'b0;
            r_wr       <= 1'b0;
            r_timeout  <= 1'b0;
            r_op_count <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_insn     <= w_insn_nxt;
            r_rs1      <= w_rs1_nxt;
            r_rs2      <= w_rs2_nxt;
            r_rd       <= w_rd_nxt;
            r_cp_valid <= w_cp_valid_nxt;
            r_wait     <= w_wait_nxt;
            r_ready    <= w_resp_nxt;
            r_wr       <= w_resp_nxt;
            r_timeout  <= w_timeout_nxt;
            r_op_count <= w_op_count_nxt;
        end
    end

    assign pcpi_wr        = r_wr;
    assign pcpi_rd        = r_rd;
    assign pcpi_wait      = r_wait;
    assign pcpi_ready     = r_ready;
    assign cp_valid       = r_cp_valid;
    assign cp_instruction = r_insn;
    assign cp_rs1         = r_rs1;
    assign cp_rs2         = r_rs2;
    assign timeout_err    = r_timeout;
    assign op_count       = r_op_count;

endmodule

// File: tb/tb_pcpi_m_dispatch.sv
// Directed bench for pcpi_m_dispatch: cycle-level vector table plus hand sequences
// for non-M filtering, timeout/drain, and reset mid-transaction.
module tb_pcpi_m_dispatch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;
    logic        cp_valid;
    logic [31:0] cp_instruction, cp_rs1, cp_rs2;
    logic        cp_ready, cp_busy;
    logic [31:0] cp_rd;
    logic        timeout_err;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] MUL   = 32'h0200_0033;
    localparam logic [31:0] DIV   = 32'h0200_4033;
    localparam logic [31:0] MULHU = 32'h0200_3033;

    pcpi_m_dispatch #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .pcpi_valid     (pcpi_valid),
        .pcpi_insn      (pcpi_insn),
        .pcpi_rs1       (pcpi_rs1),
        .pcpi_rs2       (pcpi_rs2),
        .pcpi_wr        (pcpi_wr),
        .pcpi_rd        (pcpi_rd),
        .pcpi_wait      (pcpi_wait),
        .pcpi_ready     (pcpi_ready),
        .cp_valid       (cp_valid),
        .cp_instruction (cp_instruction),
        .cp_rs1         (cp_rs1),
        .cp_rs2         (cp_rs2),
        .cp_ready       (cp_ready),
        .cp_busy        (cp_busy),
        .cp_rd          (cp_rd),
        .timeout_err    (timeout_err),
        .op_count       (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        rdy;
        logic        busy;
        logic [31:0] cprd;
        logic        e_cpv;
        logic        e_wait;
        logic        e_rsp;
        logic [31:0] e_rd;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic valid, input logic [31:0] insn,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic rdy, input logic busy, input logic [31:0] cprd,
                                input logic e_cpv, input logic e_wait, input logic e_rsp,
                                input logic [31:0] e_rd, input logic [15:0] e_cnt);
        vec_t v;
        v.valid = valid; v.insn = insn; v.rs1 = rs1; v.rs2 = rs2;
        v.rdy = rdy; v.busy = busy; v.cprd = cprd;
        v.e_cpv = e_cpv; v.e_wait = e_wait; v.e_rsp = e_rsp;
        v.e_rd = e_rd; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic rdy, input logic busy,
                         input logic [31:0] cprd);
        pcpi_valid = valid; pcpi_insn = insn; pcpi_rs1 = rs1; pcpi_rs2 = rs2;
        cp_ready = rdy; cp_busy = busy; cp_rd = cprd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr"},     32'(pcpi_wr),        32'd0);
        chk({tag, "_rd"},     pcpi_rd,             32'd0);
        chk({tag, "_wait"},   32'(pcpi_wait),      32'd0);
        chk({tag, "_ready"},  32'(pcpi_ready),     32'd0);
        chk({tag, "_cpv"},    32'(cp_valid),       32'd0);
        chk({tag, "_cpinsn"}, cp_instruction,      32'd0);
        chk({tag, "_cprs1"},  cp_rs1,              32'd0);
        chk({tag, "_cprs2"},  cp_rs2,              32'd0);
        chk({tag, "_to"},     32'(timeout_err),    32'd0);
        chk({tag, "_cnt"},    32'(op_count),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] prod;
        logic [31:0] mulhu_exp;
        int          hi;
        logic        saw_rdy;

        // MUL 0x15 * 0x788, stub busy then ready on the third cycle
        vq.push_back(mk(1, MUL, 32'h15, 32'h788, 0, 0, 32'h0,    1, 1, 0, 32'h0,    16'd0));
        vq.push_back(mk(1, MUL, 32'h15, 32'h788, 0, 1, 32'h0,    0, 1, 0, 32'h0,    16'd0));
        vq.push_back(mk(1, MUL, 32'h15, 32'h788, 0, 1, 32'h0,    0, 1, 0, 32'h0,    16'd0));
        vq.push_back(mk(1, MUL, 32'h15, 32'h788, 1, 0, 32'h9E28, 0, 0, 1, 32'h9E28, 16'd1));
        vq.push_back(mk(1, MUL, 32'h15, 32'h788, 0, 0, 32'h0,    0, 0, 0, 32'h0,    16'd1));
        vq.push_back(mk(1, MUL, 32'h15, 32'h788, 0, 0, 32'h0,    0, 0, 0, 32'h0,    16'd1));
        vq.push_back(mk(0, MUL, 32'h15, 32'h788, 0, 0, 32'h0,    0, 0, 0, 32'h0,    16'd1));
        vq.push_back(mk(0, MUL, 32'h15, 32'h788, 0, 0, 32'h0,    0, 0, 0, 32'h0,    16'd1));
        // DIV by zero, ready in the issue cycle, valid held an extra cycle
        vq.push_back(mk(1, DIV, 32'h9502F900, 0, 0, 0, 32'h0,         1, 1, 0, 32'h0,         16'd1));
        vq.push_back(mk(1, DIV, 32'h9502F900, 0, 1, 0, 32'hFFFFFFFF,  0, 0, 1, 32'hFFFFFFFF,  16'd2));
        vq.push_back(mk(1, DIV, 32'h9502F900, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         16'd2));
        vq.push_back(mk(1, DIV, 32'h9502F900, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         16'd2));
        vq.push_back(mk(0, DIV, 32'h9502F900, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,         16'd2));
        // Abort in WAIT, request ignored in DRAIN, late result discarded, next MUL completes
        vq.push_back(mk(1, MUL, 32'd3, 32'd5, 0, 0, 32'h0,    1, 1, 0, 32'h0,  16'd2));
        vq.push_back(mk(1, MUL, 32'd3, 32'd5, 0, 1, 32'h0,    0, 1, 0, 32'h0,  16'd2));
        vq.push_back(mk(0, MUL, 32'd3, 32'd5, 0, 1, 32'h0,    0, 0, 0, 32'h0,  16'd2));
        vq.push_back(mk(1, MUL, 32'd3, 32'd5, 0, 1, 32'h0,    0, 0, 0, 32'h0,  16'd2));
        vq.push_back(mk(0, MUL, 32'd3, 32'd5, 1, 0, 32'h1234, 0, 0, 0, 32'h0,  16'd2));
        vq.push_back(mk(1, MUL, 32'd6, 32'd7, 0, 0, 32'h0,    1, 1, 0, 32'h0,  16'd2));
        vq.push_back(mk(1, MUL, 32'd6, 32'd7, 1, 0, 32'h2A,   0, 0, 1, 32'h2A, 16'd3));
        vq.push_back(mk(0, MUL, 32'd6, 32'd7, 0, 0, 32'h0,    0, 0, 0, 32'h0,  16'd3));
        vq.push_back(mk(0, MUL, 32'd6, 32'd7, 0, 0, 32'h0,    0, 0, 0, 32'h0,  16'd3));
        // cp_ready coincident with abort in WAIT: straight to IDLE, next request accepted at once
        vq.push_back(mk(1, MUL, 32'd2, 32'd2, 0, 0, 32'h0, 1, 1, 0, 32'h0, 16'd3));
        vq.push_back(mk(1, MUL, 32'd2, 32'd2, 0, 1, 32'h0, 0, 1, 0, 32'h0, 16'd3));
        vq.push_back(mk(0, MUL, 32'd2, 32'd2, 1, 0, 32'h4, 0, 0, 0, 32'h0, 16'd3));
        vq.push_back(mk(1, MUL, 32'd2, 32'd2, 0, 0, 32'h0, 1, 1, 0, 32'h0, 16'd3));
        vq.push_back(mk(1, MUL, 32'd2, 32'd2, 1, 0, 32'h4, 0, 0, 1, 32'h4, 16'd4));
        vq.push_back(mk(0, MUL, 32'd2, 32'd2, 0, 0, 32'h0, 0, 0, 0, 32'h0, 16'd4));
        vq.push_back(mk(0, MUL, 32'd2, 32'd2, 0, 0, 32'h0, 0, 0, 0, 32'h0, 16'd4));

        resetn = 1'b0;
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        resetn = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].valid, vq[i].insn, vq[i].rs1, vq[i].rs2, vq[i].rdy, vq[i].busy, vq[i].cprd);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ctl", i),
                32'({cp_valid, pcpi_wait, pcpi_ready, pcpi_wr, timeout_err}),
                32'({vq[i].e_cpv, vq[i].e_wait, vq[i].e_rsp, vq[i].e_rsp, 1'b0}));
            chk($sformatf("vec%0d_rd", i), pcpi_rd, vq[i].e_rd);
            chk($sformatf("vec%0d_opcnt", i), 32'(op_count), 32'(vq[i].e_cnt));
            if (vq[i].e_cpv) begin
                chk($sformatf("vec%0d_cpinsn", i), cp_instruction, vq[i].insn);
                chk($sformatf("vec%0d_cprs1", i), cp_rs1, vq[i].rs1);
                chk($sformatf("vec%0d_cprs2", i), cp_rs2, vq[i].rs2);
            end
        end

        // Non-M instructions held valid are ignored
        @(negedge clk);
        drive(1, 32'h0000_0033, 32'h11, 32'h22, 0, 0, 32'h0);
        for (int c = 0; c < 24; c++) begin
            if (c == 20) pcpi_insn = 32'h0200_0013;
            @(posedge clk);
            #1;
            chk($sformatf("nonm%0d", c), 32'({cp_valid, pcpi_wait, pcpi_ready}), 32'd0);
        end
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // Timeout: stub never ready
        @(negedge clk);
        drive(1, MUL, 32'd9, 32'd9, 0, 0, 32'h0);
        hi = 0;
        saw_rdy = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            #1;
            if (pcpi_wait) hi++;
            if (pcpi_ready) saw_rdy = 1'b1;
        end
        chk("to_wait_cycles", 32'(hi), 32'd8);
        chk("to_wait_low", 32'(pcpi_wait), 32'd0);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_no_ready", 32'(saw_rdy), 32'd0);
        // DRAIN times out after another 8 cycles, then the still-valid request is accepted
        for (int c = 10; c <= 17; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("drain%0d", c), 32'({cp_valid, pcpi_wait, pcpi_ready}), 32'd0);
        end
        @(posedge clk);
        #1;
        chk("drain_exit_issue", 32'(cp_valid), 32'd1);
        @(negedge clk);
        cp_ready = 1'b1;
        cp_rd = 32'h51;
        @(posedge clk);
        #1;
        chk("post_to_ready", 32'({pcpi_ready, pcpi_wr}), 32'd3);
        chk("post_to_rd", pcpi_rd, 32'h51);
        chk("post_to_opcnt", 32'(op_count), 32'd5);
        chk("to_sticky", 32'(timeout_err), 32'd1);
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);

        // Reset during WAIT
        @(negedge clk);
        drive(1, MUL, 32'd1, 32'd1, 0, 0, 32'h0);
        @(negedge clk);
        cp_busy = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwait_wait", 32'(pcpi_wait), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        resetn = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        prod = 64'(32'hFFF0_0015) * 64'(32'hFAA0_0788);
        mulhu_exp = prod[63:32];
        @(negedge clk);
        drive(1, MULHU, 32'hFFF0_0015, 32'hFAA0_0788, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk("mulhu_cpv", 32'(cp_valid), 32'd1);
        chk("mulhu_cpinsn", cp_instruction, MULHU);
        chk("mulhu_cprs1", cp_rs1, 32'hFFF0_0015);
        chk("mulhu_cprs2", cp_rs2, 32'hFAA0_0788);
        @(negedge clk);
        cp_busy = 1'b1;
        @(negedge clk);
        drive(1, MULHU, 32'hFFF0_0015, 32'hFAA0_0788, 1, 0, mulhu_exp);
        @(posedge clk);
        #1;
        chk("mulhu_ready", 32'({pcpi_ready, pcpi_wr}), 32'd3);
        chk("mulhu_rd", pcpi_rd, mulhu_exp);
        chk("mulhu_opcnt", 32'(op_count), 32'd1);
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk("mulhu_hold_zero", 32'({pcpi_ready, pcpi_wr, pcpi_wait, cp_valid}), 32'd0);
        chk("mulhu_hold_rd", pcpi_rd, 32'd0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
